fwd_scoreboard_unit: RTL and testbench
======================================

Name: fwd_scoreboard_unit

Overview:
Parametrised EX-stage operand forwarding and hazard unit, the successor to the fixed 2-source/2-stage forwarding mux.
- Forwards from NUM_STG younger-to-older pipeline stages onto NUM_SRC read ports.
- Detects load-use hazards: a matching stage whose data is not yet valid.
- Holds a per-register countdown scoreboard for long-latency writers (mul/div), raising a stall until each result is due.
- Sits between ID/EX register outputs and the ALU operand muxes; also drives the IF/ID/EX stall network.

Parameters:
NUM_SRC, 2, number of EX source-operand read ports
NUM_STG, 2, number of forwarding stages; index 0 = youngest (ME), highest priority
XLEN, 32, data width (`DATA_WIDTH)
RA_W, 5, register address width (`REG_ADDR_WIDTH)
LAT_W, 3, width of long-latency countdown (max latency 2^LAT_W-1)
PERF_W, 32, stall performance counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
ex_rs_valid  in  NUM_SRC  port i actually reads a register
ex_rs_addr  in  NUM_SRC*RA_W  source register addresses, port i at [i*RA_W +: RA_W]
ex_rs_data  in  NUM_SRC*XLEN  register-file values
stg_wb_en  in  NUM_STG  stage j will write rd
stg_rd_addr  in  NUM_STG*RA_W  stage j destination
stg_data  in  NUM_STG*XLEN  stage j result
stg_data_vld  in  NUM_STG  stage j result is available now (0 for a load still in ME)
issue_valid  in  1  long-latency op leaves EX this cycle
issue_rd  in  RA_W  its destination
issue_lat  in  LAT_W  cycles until its result reaches a forwarding stage
flush  in  1  pipeline flush (branch/trap)
perf_clr  in  1  clear stall counter
ex_rs_fwd  out  NUM_SRC*XLEN  forwarded operands
stall  out  1  hold IF/ID/EX, bubble into ME
perf_stall_cnt  out  PERF_W  cycles with stall=1

Behaviour:
- Clock and reset: one clock `clk`; `rst` is synchronous and active-high. All state changes on the rising edge of `clk`.
- Forwarding (combinational, 0 latency). Per port i, select the lowest j where all hold:
  - stg_wb_en[j]=1
  - stg_rd_addr[j]!=0
  - stg_rd_addr[j]==ex_rs_addr[i]
- If such a j exists, ex_rs_fwd[i] = stg_data[j]; otherwise ex_rs_data[i].
- Address 0 never forwards and is never busy.
- Load-use hazard for port i: ex_rs_valid[i] is set and the selected j has stg_data_vld[j]=0. An older valid stage must not be used instead.
- Scoreboard: cnt[1..2^RA_W-1], LAT_W bits each; busy[r] = (cnt[r]!=0).
  - Each cycle, any nonzero cnt decrements by 1.
  - issue_valid with issue_rd!=0 and issue_lat!=0 loads cnt[issue_rd] <= issue_lat. This overrides the same-cycle decrement and overwrites any prior value (WAW: newest wins).
  - issue_lat=0 or issue_rd=0: no scoreboard change.
- Scoreboard hazard for port i: ex_rs_valid[i] and busy[ex_rs_addr[i]].
- stall = OR of load-use and scoreboard hazards over all ports (combinational from current state).
- Timing example: an issue with L=2 at edge N blocks a dependent reader during cycles N..N+1 and releases it in cycle N+2.
- flush: all cnt <= 0 next edge, taking priority over a same-cycle issue. flush does not gate the combinational stall in the flush cycle.
- perf_stall_cnt:
  - Increments on each edge where stall=1, saturating at all-ones.
  - perf_clr zeroes it; perf_clr wins over a same-cycle increment.
- Reset: every cnt=0 and perf_stall_cnt=0. After reset, stall=0 until inputs create a hazard; ex_rs_fwd follows inputs. Reset mid-countdown discards all pending entries.

Decomposition:
- Defines.vh (shared): `DATA_WIDTH, `REG_ADDR_WIDTH, new `FWD_LAT_WIDTH and `PERF_CNT_WIDTH.
- One sub-module, fwd_prio_mux: a single port's N-stage priority match. It outputs the forwarded data, a hit flag, and the hit stage's vld. The top instantiates it NUM_SRC times in a generate loop.
- Scoreboard and perf counter stay in the top.

Test Plan:
- Forward priority. Setup: NUM_STG=2, ME writes x5=0xAAAA_0001, WB writes x5=0xBBBB_0002, port0 reads x5, port1 reads x6 with rf=0x66. Required: ex_rs_fwd0=0xAAAA_0001, ex_rs_fwd1=0x66, stall=0.
- x0 guard. Setup: ME wb_en=1, rd=0, data=0xDEAD; port0 reads x0 with rf=0. Required: ex_rs_fwd0=0, stall=0.
- Load-use. Setup: ME rd=x7, vld=0; WB rd=x7, vld=1; port1 reads x7 with valid=1. Required: stall=1, WB value not used. With ex_rs_valid=0: stall=0.
- Countdown. Setup: issue x9, lat=3, at edge 0; reader of x9 every cycle. Required: stall=1 in cycles 0-2, 0 in cycle 3; perf_stall_cnt=3 afterwards.
- WAW and flush. Setup: issue x4 lat=5, then two cycles later issue x4 lat=1. Required: stall clears after 1 cycle. Separately, issue x4 lat=7 with flush in the same cycle: cnt stays 0, no stall next cycle.
- Reset and saturation. Setup: rst asserted mid-countdown. Required: stall=0 next cycle, counter=0. Setup: PERF_W=3 with 9 consecutive stall cycles. Required: counter holds 7; perf_clr gives 0 next edge.

Source files
------------

// File: rtl/fwd_scoreboard_unit_pkg.sv
// Shared widths and hazard classification for the EX-stage forwarding/scoreboard unit.
package fwd_scoreboard_unit_pkg;
    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int FWD_LAT_WIDTH  = 3;
    localparam int PERF_CNT_WIDTH = 32;

    typedef enum logic [1:0] {
        HAZ_NONE     = 2'd0,
        HAZ_LOAD_USE = 2'd1,
        HAZ_BUSY     = 2'd2,
        HAZ_BOTH     = 2'd3
    } hazard_e;

    function automatic hazard_e classify_hazard(input logic load_use, input logic busy);
        return hazard_e'({busy, load_use});
    endfunction
endpackage

// File: rtl/fwd_prio_mux.sv
// Single read port priority match across forwarding stages; stage 0 (youngest) wins.
module fwd_prio_mux
    import fwd_scoreboard_unit_pkg::*;
#(
    parameter int NUM_STG = 2,
    parameter int XLEN    = DATA_WIDTH,
    parameter int RA_W    = REG_ADDR_WIDTH
) (
    input  logic [RA_W-1:0]         rs_addr,
    input  logic [XLEN-1:0]         rs_data,
    input  logic [NUM_STG-1:0]      stg_wb_en,
    input  logic [NUM_STG*RA_W-1:0] stg_rd_addr,
    input  logic [NUM_STG*XLEN-1:0] stg_data,
    input  logic [NUM_STG-1:0]      stg_data_vld,
    output logic [XLEN-1:0]         fwd_data,
    output logic                    hit,
    output logic                    hit_vld
);
    // First matching stage is taken even when its data is not ready, so an older stage can never mask a load-use hazard.
    always_comb begin
        fwd_data = rs_data;
        hit      = 1'b0;
        hit_vld  = 1'b0;
        for (int j = 0; j < NUM_STG; j++) begin
            if (!hit && stg_wb_en[j] &&
                (stg_rd_addr[j*RA_W +: RA_W] != {RA_W{1'b0}}) &&
                (stg_rd_addr[j*RA_W +: RA_W] == rs_addr)) begin
                hit      = 1'b1;
                hit_vld  = stg_data_vld[j];
                fwd_data = stg_data[j*XLEN +: XLEN];
            end else begin
                hit = hit;
            end
        end
    end
endmodule

// File: rtl/fwd_scoreboard_unit.sv
// EX-stage operand forwarding, load-use detection and long-latency countdown scoreboard with stall counter.
module fwd_scoreboard_unit
    import fwd_scoreboard_unit_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int NUM_STG = 2,
    parameter int XLEN    = DATA_WIDTH,
    parameter int RA_W    = REG_ADDR_WIDTH,
    parameter int LAT_W   = FWD_LAT_WIDTH,
    parameter int PERF_W  = PERF_CNT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_SRC-1:0]      ex_rs_valid,
    input  logic [NUM_SRC*RA_W-1:0] ex_rs_addr,
    input  logic [NUM_SRC*XLEN-1:0] ex_rs_data,
    input  logic [NUM_STG-1:0]      stg_wb_en,
    input  logic [NUM_STG*RA_W-1:0] stg_rd_addr,
    input  logic [NUM_STG*XLEN-1:0] stg_data,
    input  logic [NUM_STG-1:0]      stg_data_vld,
    input  logic                    issue_valid,
    input  logic [RA_W-1:0]         issue_rd,
    input  logic [LAT_W-1:0]        issue_lat,
    input  logic                    flush,
    input  logic                    perf_clr,
    output logic [NUM_SRC*XLEN-1:0] ex_rs_fwd,
    output logic                    stall,
    output logic [PERF_W-1:0]       perf_stall_cnt
);
    localparam int NREG = 1 << RA_W;

    logic [LAT_W-1:0]   cnt_r [NREG];
    logic [PERF_W-1:0]  perf_r;
    logic [NUM_SRC-1:0] hit_s;
    logic [NUM_SRC-1:0] hit_vld_s;
    logic               stall_s;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_port
        fwd_prio_mux #(
            .NUM_STG (NUM_STG),
            .XLEN    (XLEN),
            .RA_W    (RA_W)
        ) u_mux (
            .rs_addr      (ex_rs_addr[i*RA_W +: RA_W]),
            .rs_data      (ex_rs_data[i*XLEN +: XLEN]),
            .stg_wb_en    (stg_wb_en),
            .stg_rd_addr  (stg_rd_addr),
            .stg_data     (stg_data),
            .stg_data_vld (stg_data_vld),
            .fwd_data     (ex_rs_fwd[i*XLEN +: XLEN]),
            .hit          (hit_s[i]),
            .hit_vld      (hit_vld_s[i])
        );
    end

    // Per-register countdown; entry 0 is tied to zero so x0 is never busy.
    always_ff @(posedge clk) begin
        cnt_r[0] <= {LAT_W{1'b0}};
        for (int r = 1; r < NREG; r++) begin
            if (rst || flush) begin
                cnt_r[r] <= {LAT_W{1'b0}};
            end else if (issue_valid && (issue_rd == RA_W'(r)) && (issue_lat != {LAT_W{1'b0}})) begin
                cnt_r[r] <= issue_lat;
            end else if (cnt_r[r] != {LAT_W{1'b0}}) begin
                cnt_r[r] <= cnt_r[r] - LAT_W'(1);
            end else begin
                cnt_r[r] <= cnt_r[r];
            end
        end
    end

    // Stall is the OR of every port's load-use or scoreboard hazard.
    always_comb begin
        stall_s = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (classify_hazard(ex_rs_valid[i] & hit_s[i] & ~hit_vld_s[i],
                                ex_rs_valid[i] & (cnt_r[ex_rs_addr[i*RA_W +: RA_W]] != {LAT_W{1'b0}}))
                != HAZ_NONE) begin
                stall_s = 1'b1;
            end else begin
                stall_s = stall_s;
            end
        end
    end

    // Saturating stall-cycle counter; clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || perf_clr) begin
            perf_r <= {PERF_W{1'b0}};
        end else if (stall_s && (perf_r != {PERF_W{1'b1}})) begin
            perf_r <= perf_r + PERF_W'(1);
        end else begin
            perf_r <= perf_r;
        end
    end

    assign stall          = stall_s;
    assign perf_stall_cnt = perf_r;
endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// Directed plus randomized check of forwarding, hazards, scoreboard and stall counter against a ready-time model.
module tb_fwd_scoreboard_unit;
    localparam int NS = 2, NG = 2, XL = 32, RW = 5, LW = 3, PW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [NS-1:0]     ex_rs_valid;
    logic [NS*RW-1:0]  ex_rs_addr;
    logic [NS*XL-1:0]  ex_rs_data;
    logic [NG-1:0]     stg_wb_en;
    logic [NG*RW-1:0]  stg_rd_addr;
    logic [NG*XL-1:0]  stg_data;
    logic [NG-1:0]     stg_data_vld;
    logic              issue_valid;
    logic [RW-1:0]     issue_rd;
    logic [LW-1:0]     issue_lat;
    logic              flush;
    logic              perf_clr;
    logic [NS*XL-1:0]  ex_rs_fwd, ex_rs_fwd3;
    logic              stall, stall3;
    logic [PW-1:0]     perf_stall_cnt;
    logic [2:0]        perf3;

    fwd_scoreboard_unit #(.NUM_SRC(NS), .NUM_STG(NG), .XLEN(XL), .RA_W(RW), .LAT_W(LW), .PERF_W(PW)) dut (
        .clk(clk), .rst(rst), .ex_rs_valid(ex_rs_valid), .ex_rs_addr(ex_rs_addr), .ex_rs_data(ex_rs_data),
        .stg_wb_en(stg_wb_en), .stg_rd_addr(stg_rd_addr), .stg_data(stg_data), .stg_data_vld(stg_data_vld),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_lat(issue_lat), .flush(flush),
        .perf_clr(perf_clr), .ex_rs_fwd(ex_rs_fwd), .stall(stall), .perf_stall_cnt(perf_stall_cnt));

    fwd_scoreboard_unit #(.NUM_SRC(NS), .NUM_STG(NG), .XLEN(XL), .RA_W(RW), .LAT_W(LW), .PERF_W(3)) dut3 (
        .clk(clk), .rst(rst), .ex_rs_valid(ex_rs_valid), .ex_rs_addr(ex_rs_addr), .ex_rs_data(ex_rs_data),
        .stg_wb_en(stg_wb_en), .stg_rd_addr(stg_rd_addr), .stg_data(stg_data), .stg_data_vld(stg_data_vld),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_lat(issue_lat), .flush(flush),
        .perf_clr(perf_clr), .ex_rs_fwd(ex_rs_fwd3), .stall(stall3), .perf_stall_cnt(perf3));

    // Model: a register is busy while the current cycle index is below its ready cycle.
    longint ready [32];
    longint cur;
    longint ref_perf;
    int     ref_perf3;
    int     total, bad;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_busy(input int r);
        return (r != 0) && (cur < ready[r]);
    endfunction

    task automatic idle();
        rst = 1'b0; ex_rs_valid = '0; ex_rs_addr = '0; ex_rs_data = '0;
        stg_wb_en = '0; stg_rd_addr = '0; stg_data = '0; stg_data_vld = '0;
        issue_valid = 1'b0; issue_rd = '0; issue_lat = '0; flush = 1'b0; perf_clr = 1'b0;
    endtask

    task automatic set_port(input int i, input logic v, input int a, input logic [XL-1:0] d);
        ex_rs_valid[i] = v;
        ex_rs_addr[i*RW +: RW] = RW'(a);
        ex_rs_data[i*XL +: XL] = d;
    endtask

    task automatic set_stg(input int j, input logic en, input int a, input logic [XL-1:0] d, input logic v);
        stg_wb_en[j] = en;
        stg_rd_addr[j*RW +: RW] = RW'(a);
        stg_data[j*XL +: XL] = d;
        stg_data_vld[j] = v;
    endtask

    // Check combinational outputs mid-cycle, then advance the model over the next rising edge.
    task automatic tick();
        logic [XL-1:0] ef;
        logic es, found;
        int a;
        @(negedge clk);
        es = 1'b0;
        for (int i = 0; i < NS; i++) begin
            a = int'(ex_rs_addr[i*RW +: RW]);
            ef = ex_rs_data[i*XL +: XL];
            found = 1'b0;
            for (int j = 0; j < NG; j++) begin
                if (!found && stg_wb_en[j] && a != 0 && int'(stg_rd_addr[j*RW +: RW]) == a) begin
                    found = 1'b1;
                    ef = stg_data[j*XL +: XL];
                    if (ex_rs_valid[i] && !stg_data_vld[j]) es = 1'b1;
                end
            end
            if (ex_rs_valid[i] && m_busy(a)) es = 1'b1;
            chk($sformatf("fwd%0d", i), 64'(ex_rs_fwd[i*XL +: XL]), 64'(ef));
        end
        chk("stall", 64'(stall), 64'(es));
        chk("perf", 64'(perf_stall_cnt), 64'(ref_perf));
        chk("perf3", 64'(perf3), 64'(ref_perf3));
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < 32; r++) ready[r] = 0;
            ref_perf = 0;
            ref_perf3 = 0;
        end else begin
            if (perf_clr) begin
                ref_perf = 0; ref_perf3 = 0;
            end else if (es) begin
                ref_perf = ref_perf + 1;
                if (ref_perf3 < 7) ref_perf3++;
            end
            if (flush) begin
                for (int r = 0; r < 32; r++) ready[r] = 0;
            end else if (issue_valid && issue_rd != 0 && issue_lat != 0) begin
                ready[issue_rd] = cur + 1 + longint'(issue_lat);
            end
        end
        cur++;
        #1;
    endtask

    initial begin
        total = 0; bad = 0; cur = 0; ref_perf = 0; ref_perf3 = 0;
        for (int r = 0; r < 32; r++) ready[r] = 0;
        idle();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Forward priority
        set_stg(0, 1'b1, 5, 32'hAAAA_0001, 1'b1);
        set_stg(1, 1'b1, 5, 32'hBBBB_0002, 1'b1);
        set_port(0, 1'b1, 5, 32'h0000_0055);
        set_port(1, 1'b1, 6, 32'h0000_0066);
        #1;
        chk("prio_fwd0", 64'(ex_rs_fwd[31:0]), 64'h0000_0000_AAAA_0001);
        chk("prio_fwd1", 64'(ex_rs_fwd[63:32]), 64'h0000_0000_0000_0066);
        chk("prio_stall", 64'(stall), 64'h0);
        tick();

        // x0 guard
        idle();
        set_stg(0, 1'b1, 0, 32'h0000_DEAD, 1'b1);
        set_port(0, 1'b1, 0, 32'h0);
        #1;
        chk("x0_fwd0", 64'(ex_rs_fwd[31:0]), 64'h0);
        chk("x0_stall", 64'(stall), 64'h0);
        tick();

        // Load-use must not fall back to the valid older stage
        idle();
        set_stg(0, 1'b1, 7, 32'h7777_0000, 1'b0);
        set_stg(1, 1'b1, 7, 32'h7777_1111, 1'b1);
        set_port(1, 1'b1, 7, 32'h0);
        #1;
        chk("lu_stall", 64'(stall), 64'h1);
        chk("lu_fwd1", 64'(ex_rs_fwd[63:32]), 64'h0000_0000_7777_0000);
        tick();
        ex_rs_valid = '0;
        #1;
        chk("lu_novalid_stall", 64'(stall), 64'h0);
        tick();

        // Countdown lat=3
        idle(); perf_clr = 1'b1; tick();
        perf_clr = 1'b0;
        set_port(0, 1'b1, 9, 32'h9);
        issue_valid = 1'b1; issue_rd = 5'd9; issue_lat = 3'd3;
        tick();
        issue_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 chk("cd_stall_busy", 64'(stall), 64'h1);
            tick();
        end
        #1;
        chk("cd_stall_free", 64'(stall), 64'h0);
        chk("cd_perf", 64'(perf_stall_cnt), 64'h3);
        tick();

        // WAW: newest issue wins
        idle();
        set_port(0, 1'b1, 4, 32'h4);
        issue_valid = 1'b1; issue_rd = 5'd4; issue_lat = 3'd5;
        tick();
        issue_valid = 1'b0;
        tick(); tick();
        issue_valid = 1'b1; issue_lat = 3'd1;
        tick();
        issue_valid = 1'b0;
        #1 chk("waw_busy", 64'(stall), 64'h1);
        tick();
        #1 chk("waw_free", 64'(stall), 64'h0);
        tick();

        // Flush beats same-cycle issue
        issue_valid = 1'b1; issue_rd = 5'd4; issue_lat = 3'd7; flush = 1'b1;
        tick();
        issue_valid = 1'b0; flush = 1'b0;
        #1 chk("flush_stall", 64'(stall), 64'h0);
        tick();

        // Reset mid-countdown
        issue_valid = 1'b1; issue_rd = 5'd4; issue_lat = 3'd6;
        tick();
        issue_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_stall", 64'(stall), 64'h0);
        chk("rst_perf", 64'(perf_stall_cnt), 64'h0);
        tick();

        // Saturation of the 3-bit counter
        idle(); perf_clr = 1'b1; tick();
        perf_clr = 1'b0;
        set_stg(0, 1'b1, 7, 32'h1, 1'b0);
        set_port(1, 1'b1, 7, 32'h0);
        for (int k = 0; k < 9; k++) tick();
        chk("sat_perf3", 64'(perf3), 64'h7);
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        #1 chk("clr_perf3", 64'(perf3), 64'h0);
        tick();

        // Randomized traffic on a small register window to force collisions
        for (int n = 0; n < 400; n++) begin
            idle();
            for (int i = 0; i < NS; i++) set_port(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom);
            for (int j = 0; j < NG; j++) set_stg(j, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom,
                                                 1'($urandom_range(0, 3) != 0));
            issue_valid = ($urandom_range(0, 3) == 0);
            issue_rd    = RW'($urandom_range(0, 7));
            issue_lat   = LW'($urandom_range(0, 7));
            flush       = ($urandom_range(0, 19) == 0);
            perf_clr    = ($urandom_range(0, 29) == 0);
            rst         = ($urandom_range(0, 59) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
